// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver clocked by a baud*OVERSAMPLE tick.
// Synchronises rx, qualifies the start bit, majority-votes three mid-bit
// samples per bit and emits one-cycle rx_valid / frame_err pulses.
// The shift register assumes DATA_BITS >= 2.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS) + 1;

  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_M0   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_M1   = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_M2   = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t                 state_q, state_d;
  logic                   rx_meta_q, rx_meta_d;
  logic                   rx_s_q, rx_s_d;
  logic [SW-1:0]          s_cnt_q, s_cnt_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [1:0]             samp_q, samp_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   frame_err_q, frame_err_d;

  logic vote, vote_pt, bit_end;

  // Third sample is the live synchronised line on the vote tick.
  assign vote    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
  assign vote_pt = (s_cnt_q == S_M2);
  assign bit_end = (s_cnt_q == S_LAST);

  // State and datapath registers; the synchroniser resets to idle-high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      s_cnt_q     <= '0;
      bit_cnt_q   <= '0;
      samp_q      <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      s_cnt_q     <= s_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      samp_q      <= samp_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next state: only advances on baud ticks.
  always_comb begin
    state_d = state_q;
    if (baud_tick) begin
      case (state_q)
        IDLE:    if (!rx_s_q) state_d = START;
        START:   if (vote_pt && vote) state_d = IDLE;
                 else if (bit_end)    state_d = DATA;
        DATA:    if (bit_end && bit_cnt_q == B_LAST) state_d = STOP;
        STOP:    if (vote_pt) state_d = vote ? IDLE : BRK;
        BRK:     if (rx_s_q) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Counters, sampling, shifting and the registered output pulses.
  always_comb begin
    rx_meta_d   = rx;
    rx_s_d      = rx_meta_q;
    s_cnt_d     = s_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    samp_d      = samp_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    if (baud_tick) begin
      // Restart the bit timer on any state change so each state starts at 0.
      if (state_q == IDLE || state_q == BRK || state_d != state_q || bit_end)
        s_cnt_d = '0;
      else
        s_cnt_d = s_cnt_q + SW'(1);
      if (s_cnt_q == S_M0) samp_d[0] = rx_s_q;
      if (s_cnt_q == S_M1) samp_d[1] = rx_s_q;
      if (state_q == START && bit_end) bit_cnt_d = '0;
      if (state_q == DATA) begin
        if (vote_pt) shift_d = {vote, shift_q[DATA_BITS-1:1]};
        if (bit_end && bit_cnt_q != B_LAST) bit_cnt_d = bit_cnt_q + BW'(1);
      end
      if (state_q == STOP && vote_pt) begin
        if (vote) begin
          rx_data_d  = shift_q;
          rx_valid_d = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
      end
    end
  end

  // Outputs straight from registers; busy decodes the state.
  always_comb begin
    rx_data   = rx_data_q;
    rx_valid  = rx_valid_q;
    frame_err = frame_err_q;
    busy      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed + random frames against a byte-queue reference model.
module tb_uart_rx;
  localparam int BIT_CLKS = 432;   // 16 ticks of 27 clks

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, busy;

  int         n_vec = 0, n_bad = 0;
  int         n_ferr = 0, n_both = 0;
  bit         busy_seen = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] exp_last = 8'h00;

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
  );

  always #10 clk = ~clk;

  // 50 MHz / 27 tick generator, driven away from the active edge
  initial begin : tick_gen
    int tcnt;
    tcnt = 0;
    forever begin
      @(negedge clk);
      baud_tick = (tcnt == 26);
      tcnt = (tcnt == 26) ? 0 : tcnt + 1;
    end
  end

  // Event recorder: captured bytes and error pulses
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rx_valid) got_q.push_back(rx_data);
      if (frame_err) n_ferr++;
      if (rx_valid && frame_err) n_both++;
      if (busy) busy_seen = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_frames(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      chk({tag, "_data"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic send_bit(input bit b);
    rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  // Whole 8N1 frame; optional one-tick inversion in the middle of one bit.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int glitch_bit = -1);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == glitch_bit) begin
        rx = d[i];  repeat (203) @(negedge clk);
        rx = ~d[i]; repeat (27)  @(negedge clk);
        rx = d[i];  repeat (202) @(negedge clk);
      end else begin
        send_bit(d[i]);
      end
    end
    send_bit(stop_ok);
    if (stop_ok) begin
      exp_q.push_back(d);
      exp_last = d;
    end
  endtask

  initial begin : stim
    logic [7:0] c3, rb;
    int gap;
    c3 = 8'hC3;

    // reset and long idle
    rst_n = 1'b0; rx = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_valid", rx_valid, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_data", rx_data, 8'h00);
    rst_n = 1'b1;
    repeat (5000) @(negedge clk);
    chk("idle_busy_seen", busy_seen, 1'b0);
    chk("idle_ferr", n_ferr, 0);
    check_frames("idle");
    chk("idle_data", rx_data, 8'h00);

    // single frame
    send_frame(8'h55, 1'b1);
    chk("single_busy", busy, 1'b0);
    check_frames("single");
    chk("single_ferr", n_ferr, 0);
    chk("single_hold", rx_data, exp_last);

    // back-to-back, zero gap
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    check_frames("b2b");
    chk("b2b_ferr", n_ferr, 0);

    // short start glitch
    busy_seen = 1'b0;
    rx = 1'b0; repeat (81) @(negedge clk);
    rx = 1'b1; repeat (2 * BIT_CLKS) @(negedge clk);
    check_frames("glitch_a");
    chk("glitch_a_busy", busy, 1'b0);
    chk("glitch_a_busy_seen", busy_seen, 1'b1);

    // one-tick mid-bit noise in bit 2
    send_frame(8'h0F, 1'b1, 2);
    check_frames("glitch_b");
    chk("glitch_b_data", rx_data, 8'h0F);

    // framing error followed by a long break
    send_frame(8'hFF, 1'b0);
    repeat (20 * BIT_CLKS) @(negedge clk);
    chk("brk_ferr", n_ferr, 1);
    check_frames("brk");
    chk("brk_hold", rx_data, exp_last);
    chk("brk_busy", busy, 1'b1);
    rx = 1'b1; repeat (100) @(negedge clk);
    chk("brk_release_busy", busy, 1'b0);
    send_frame(8'h81, 1'b1);
    check_frames("after_brk");
    chk("after_brk_ferr", n_ferr, 1);

    // asynchronous reset during data bit 4 of 0xC3
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(c3[i]);
    rx = c3[4];
    repeat (200) @(negedge clk);
    #3 rst_n = 1'b0;
    exp_last = 8'h00;
    #2;
    chk("mid_rst_valid", rx_valid, 1'b0);
    chk("mid_rst_ferr", frame_err, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_data", rx_data, 8'h00);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    #3 rst_n = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    check_frames("mid_rst_partial");
    chk("mid_rst_idle_busy", busy, 1'b0);
    send_frame(8'h81, 1'b1);
    check_frames("mid_rst_next");
    chk("mid_rst_next_data", rx_data, 8'h81);

    // random bytes with random idle gaps
    for (int k = 0; k < 4; k++) begin
      rb  = 8'($urandom_range(0, 255));
      gap = $urandom_range(0, 300);
      send_frame(rb, 1'b1);
      rx = 1'b1;
      repeat (gap) @(negedge clk);
    end
    repeat (50) @(negedge clk);
    check_frames("random");
    chk("random_last", rx_data, exp_last);
    chk("never_both", n_both, 0);
    chk("total_ferr", n_ferr, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
